// File: rtl/temp_mon_pkg.sv
// temp_mon_pkg: shared FSM state type, datapath widths and averaging window depth for temp_mon
package temp_mon_pkg;
  localparam int TW = 16;
  localparam int CW = 17;
  localparam int SW = 18;
  localparam int WIN = 4;
  localparam int PW = $clog2(WIN);
  typedef enum logic [2:0] {IDLE, CAPT, CONV, AVG, OUT} state_e;
endpackage

// File: rtl/temp_mon_tick.sv
// temp_mon_tick: 1 ms prescaler plus sample-period prescaler; clk/rst in, registered one-cycle ms_tick_o and sample_tick_o out
module temp_mon_tick #(
  parameter int CLK_PER_MS = 50000,
  parameter int SAMPLE_MS = 100
) (
  input  logic clk,
  input  logic rst,
  output logic ms_tick_o,
  output logic sample_tick_o
);
  localparam int MW = $clog2(CLK_PER_MS + 1);
  localparam int NW = $clog2(SAMPLE_MS + 1);
  logic [MW-1:0] ms_cnt_q, ms_cnt_d;
  logic [NW-1:0] smp_cnt_q, smp_cnt_d;
  logic ms_wrap, smp_wrap;
  always_comb begin
    ms_wrap = ms_cnt_q == MW'(CLK_PER_MS - 1);
    smp_wrap = ms_wrap && smp_cnt_q == NW'(SAMPLE_MS - 1);
    ms_cnt_d = ms_wrap ? '0 : ms_cnt_q + 1'b1;
    smp_cnt_d = smp_wrap ? '0 : ms_wrap ? smp_cnt_q + 1'b1 : smp_cnt_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ms_cnt_q <= '0;
      smp_cnt_q <= '0;
      ms_tick_o <= 1'b0;
      sample_tick_o <= 1'b0;
    end else begin
      ms_cnt_q <= ms_cnt_d;
      smp_cnt_q <= smp_cnt_d;
      ms_tick_o <= ms_wrap;
      sample_tick_o <= smp_wrap;
    end
endmodule

// File: rtl/temp_mon.sv
// temp_mon: periodic pulse-count sampler -> signed temperature (LSB 0.0625 degC) with over-temp hysteresis and fault flag
// Ports: CLK, RST (async active-high), TEMP_DATA[31:0] in; TEMP_VAL[15:0] signed, TEMP_VLD, OVER_TEMP, SENSOR_FAULT out.
// Build option: define TEMP_MON_AVG_EN for a 4-sample moving average; otherwise AVG passes the converted value through.
module temp_mon
  import temp_mon_pkg::*;
#(
  parameter int CLK_PER_MS = 50000,
  parameter int SAMPLE_MS = 100,
  parameter logic [TW-1:0] CNT_OFFSET = 16'd800,
  parameter logic signed [TW-1:0] HI_TH = 16'sd1360,
  parameter logic signed [TW-1:0] LO_TH = 16'sd1280
) (
  input  logic CLK,
  input  logic RST,
  input  logic [31:0] TEMP_DATA,
  output logic signed [TW-1:0] TEMP_VAL,
  output logic TEMP_VLD,
  output logic OVER_TEMP,
  output logic SENSOR_FAULT
);
  logic ms_tick, smp_tick;
  state_e state_q, state_d;
  logic [31:0] cap_q, cap_d;
  logic signed [CW-1:0] diff;
  logic signed [TW-1:0] conv_q, conv_d, sat, avg, val_q, val_d;
  logic bad, vld_q, vld_d, ot_q, ot_d, flt_q, flt_d;
  temp_mon_tick #(.CLK_PER_MS(CLK_PER_MS), .SAMPLE_MS(SAMPLE_MS)) u_tick (
    .clk(CLK),
    .rst(RST),
    .ms_tick_o(ms_tick),
    .sample_tick_o(smp_tick)
  );
  always_comb begin
    bad = cap_q[31:16] != '0 || cap_q[15:0] == '0;
    diff = $signed({1'b0, cap_q[15:0]}) - $signed({1'b0, CNT_OFFSET});
    // bits 16 and 15 disagree only when the result is outside the 16-bit signed range
    sat = diff[CW-1] != diff[TW-1] ? {diff[CW-1], {(TW-1){~diff[CW-1]}}} : diff[TW-1:0];
    cap_d = state_q == CAPT ? TEMP_DATA : cap_q;
    conv_d = state_q == CONV ? sat : conv_q;
    // a sample tick is always coincident with a ms tick
    state_d = state_q == IDLE ? (smp_tick && ms_tick ? CAPT : IDLE) :
              state_q == CAPT ? CONV :
              state_q == CONV ? (bad ? IDLE : AVG) :
              state_q == AVG  ? OUT : IDLE;
    val_d = state_q == AVG ? avg : val_q;
    vld_d = state_q == AVG;
    ot_d = state_q != AVG ? ot_q : avg >= HI_TH ? 1'b1 : avg <= LO_TH ? 1'b0 : ot_q;
    flt_d = state_q == CONV && bad ? 1'b1 : state_q == AVG ? 1'b0 : flt_q;
  end
`ifdef TEMP_MON_AVG_EN
  logic signed [TW-1:0] win_q [WIN];
  logic signed [TW-1:0] win_d [WIN];
  logic [PW-1:0] ptr_q;
  logic full_q;
  logic signed [SW-1:0] sum;
  // an empty window takes the new value in every slot; otherwise only the oldest slot is replaced
  always_comb begin
    sum = '0;
    for (int i = 0; i < WIN; i++) begin
      win_d[i] = full_q && PW'(i) != ptr_q ? win_q[i] : conv_q;
      sum = sum + SW'(win_d[i]);
    end
    avg = TW'(sum >>> 2);
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      for (int i = 0; i < WIN; i++) win_q[i] <= '0;
      ptr_q <= '0;
      full_q <= 1'b0;
    end else if (state_q == AVG) begin
      for (int i = 0; i < WIN; i++) win_q[i] <= win_d[i];
      ptr_q <= full_q ? ptr_q + 1'b1 : '0;
      full_q <= 1'b1;
    end else if (state_q == CONV && bad) begin
      full_q <= 1'b0;
    end
`else
  always_comb avg = conv_q;
`endif
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state_q <= IDLE;
      cap_q <= '0;
      conv_q <= '0;
      val_q <= '0;
      vld_q <= 1'b0;
      ot_q <= 1'b0;
      flt_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cap_q <= cap_d;
      conv_q <= conv_d;
      val_q <= val_d;
      vld_q <= vld_d;
      ot_q <= ot_d;
      flt_q <= flt_d;
    end
  assign TEMP_VAL = val_q;
  assign TEMP_VLD = vld_q;
  assign OVER_TEMP = ot_q;
  assign SENSOR_FAULT = flt_q;
endmodule

// File: tb/tb_temp_mon.sv
// tb_temp_mon: directed self-checking bench for temp_mon (CLK_PER_MS=10, SAMPLE_MS=2 -> one sample every 20 cycles)
module tb_temp_mon;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] data = 32'd0;
  logic signed [15:0] val;
  logic vld, ot, flt;
  int checks = 0;
  int fails = 0;
  temp_mon #(.CLK_PER_MS(10), .SAMPLE_MS(2)) dut (
    .CLK(clk),
    .RST(rst),
    .TEMP_DATA(data),
    .TEMP_VAL(val),
    .TEMP_VLD(vld),
    .OVER_TEMP(ot),
    .SENSOR_FAULT(flt)
  );
  always #5 clk = ~clk;
  // runs exactly one sample period starting just after a TEMP_VLD edge; the next strobe lands on the last cycle
  task automatic run20(input logic [31:0] d, output int nv);
    data = d;
    nv = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (vld) nv++;
    end
  endtask
  task automatic wait_first(input string name, input int exp_n);
    int n;
    bit hit;
    n = 0;
    hit = 0;
    while (!hit && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      hit = vld;
    end
    checks++;
    if (!hit || n !== exp_n) begin fails++; $display("FAIL %s got=%0d hit=%0d exp=%0d", name, n, hit, exp_n); end
  endtask
  task automatic test_reset;
    rst = 1'b1;
    data = 32'd1200;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (val !== 16'sd0) begin fails++; $display("FAIL reset_val got=%0d exp=0", val); end
    checks++; if (vld !== 1'b0) begin fails++; $display("FAIL reset_vld got=%b exp=0", vld); end
    checks++; if (ot !== 1'b0) begin fails++; $display("FAIL reset_ot got=%b exp=0", ot); end
    checks++; if (flt !== 1'b0) begin fails++; $display("FAIL reset_flt got=%b exp=0", flt); end
    @(negedge clk);
    rst = 1'b0;
    wait_first("first_vld_latency", 24);
    checks++; if (val !== 16'sd400) begin fails++; $display("FAIL first_val got=%0d exp=400", val); end
    checks++; if (ot !== 1'b0) begin fails++; $display("FAIL first_ot got=%b exp=0", ot); end
    checks++; if (flt !== 1'b0) begin fails++; $display("FAIL first_flt got=%b exp=0", flt); end
  endtask
  task automatic test_avg;
    int nv;
    logic signed [15:0] exp_v;
`ifdef TEMP_MON_AVG_EN
    exp_v = 16'sd500;
`else
    exp_v = 16'sd800;
`endif
    run20(32'd1600, nv);
    checks++; if (nv !== 1) begin fails++; $display("FAIL avg_vld_count got=%0d exp=1", nv); end
    checks++; if (val !== exp_v) begin fails++; $display("FAIL avg_val got=%0d exp=%0d", val, exp_v); end
  endtask
  task automatic test_over_temp;
    int nv;
    logic [31:0] cnt [5] = '{32'd2200, 32'd2100, 32'd2040, 32'd2000, 32'd2160};
    logic signed [15:0] tv [5] = '{16'sd1400, 16'sd1300, 16'sd1240, 16'sd1200, 16'sd1360};
    logic eo [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 5; k++) begin
      run20(32'd0, nv);
      run20(cnt[k], nv);
      checks++; if (nv !== 1) begin fails++; $display("FAIL ot_vld_count[%0d] got=%0d exp=1", k, nv); end
      checks++; if (val !== tv[k]) begin fails++; $display("FAIL ot_val[%0d] got=%0d exp=%0d", k, val, tv[k]); end
      checks++; if (ot !== eo[k]) begin fails++; $display("FAIL ot_flag[%0d] got=%b exp=%b", k, ot, eo[k]); end
    end
  endtask
  task automatic test_fault;
    int nv;
    logic [31:0] bad [3] = '{32'd0, 32'h0001_0000, 32'h0001_04B0};
    for (int k = 0; k < 3; k++) begin
      run20(bad[k], nv);
      checks++; if (nv !== 0) begin fails++; $display("FAIL fault_vld_count[%0d] got=%0d exp=0", k, nv); end
      checks++; if (flt !== 1'b1) begin fails++; $display("FAIL fault_flag[%0d] got=%b exp=1", k, flt); end
      checks++; if (val !== 16'sd1360) begin fails++; $display("FAIL fault_val_held[%0d] got=%0d exp=1360", k, val); end
      checks++; if (ot !== 1'b1) begin fails++; $display("FAIL fault_ot_held[%0d] got=%b exp=1", k, ot); end
    end
    run20(32'd1200, nv);
    checks++; if (nv !== 1) begin fails++; $display("FAIL recover_vld_count got=%0d exp=1", nv); end
    checks++; if (val !== 16'sd400) begin fails++; $display("FAIL recover_val got=%0d exp=400", val); end
    checks++; if (flt !== 1'b0) begin fails++; $display("FAIL recover_flt got=%b exp=0", flt); end
    checks++; if (ot !== 1'b0) begin fails++; $display("FAIL recover_ot got=%b exp=0", ot); end
  endtask
  task automatic test_saturation;
    int nv;
    logic signed [15:0] exp_v;
    run20(32'd0, nv);
    run20(32'd65535, nv);
    checks++; if (val !== 16'sd32767) begin fails++; $display("FAIL sat_hi_val got=%0d exp=32767", val); end
    checks++; if (ot !== 1'b1) begin fails++; $display("FAIL sat_hi_ot got=%b exp=1", ot); end
    run20(32'd0, nv);
    run20(32'd1, nv);
    checks++; if (val !== -16'sd799) begin fails++; $display("FAIL sat_lo_val got=%0d exp=-799", val); end
    checks++; if (ot !== 1'b0) begin fails++; $display("FAIL sat_lo_ot got=%b exp=0", ot); end
`ifdef TEMP_MON_AVG_EN
    exp_v = -16'sd799;
`else
    exp_v = -16'sd798;
`endif
    run20(32'd2, nv);
    checks++; if (val !== exp_v) begin fails++; $display("FAIL neg_floor_val got=%0d exp=%0d", val, exp_v); end
  endtask
  task automatic test_rst_mid;
    repeat (18) @(posedge clk);
    #1;
    data = 32'd1600;
    rst = 1'b1;
    #1;
    checks++; if (val !== 16'sd0) begin fails++; $display("FAIL midrst_val got=%0d exp=0", val); end
    checks++; if (vld !== 1'b0 || ot !== 1'b0 || flt !== 1'b0) begin fails++; $display("FAIL midrst_flags got=%b%b%b exp=000", vld, ot, flt); end
    @(negedge clk);
    rst = 1'b0;
    wait_first("midrst_vld_latency", 24);
    checks++; if (val !== 16'sd800) begin fails++; $display("FAIL midrst_val_after got=%0d exp=800", val); end
  endtask
  initial begin
    test_reset();
    test_avg();
    test_over_temp();
    test_fault();
    test_saturation();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
